bias_vector_unit: RTL and testbench

//  N_COLS-wide bias stage below the systolic array's output row: adds a per-column double-buffered

---
 rtl/bias_vector_unit_if.sv | 34 +++
 rtl/bias_vector_unit.sv | 120 ++++++++++++
 tb/tb_bias_vector_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_vector_unit_if.sv
// Bus bundle for bias_vector_unit.
// Covers bias loading, mode control, the per-column systolic beats and the registered results.
interface bias_vector_unit_if #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
);
  localparam int IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic                     load_bias_in;
  logic [IDX_W-1:0]         load_idx_in;
  logic [DATA_W-1:0]        bias_scalar_in;
  logic                     bias_switch_in;
  logic                     bias_backward_in;
  logic                     grad_clear_in;
  logic [N_COLS-1:0]        sys_valid_in;
  logic [N_COLS*DATA_W-1:0] sys_data_in;
  logic [N_COLS-1:0]        valid_out;
  logic [N_COLS*DATA_W-1:0] data_out;
  logic [N_COLS*ACC_W-1:0]  grad_acc_out;
  logic [N_COLS*DATA_W-1:0] active_bias_out;

  modport master (
    output load_bias_in, load_idx_in, bias_scalar_in, bias_switch_in,
           bias_backward_in, grad_clear_in, sys_valid_in, sys_data_in,
    input  valid_out, data_out, grad_acc_out, active_bias_out
  );

  modport slave (
    input  load_bias_in, load_idx_in, bias_scalar_in, bias_switch_in,
           bias_backward_in, grad_clear_in, sys_valid_in, sys_data_in,
    output valid_out, data_out, grad_acc_out, active_bias_out
  );
endinterface

// File: rtl/bias_vector_unit.sv
// Per-column bias stage under the systolic array.
// Forward mode adds a double-buffered saturating bias; backward mode passes data through and accumulates bias gradients.
module bias_vector_unit #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
) (
  input logic              clk,
  input logic              rst,
  bias_vector_unit_if.slave bus
);
  localparam int IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic [DATA_W-1:0] inactive_r  [N_COLS];
  logic [DATA_W-1:0] active_r    [N_COLS];
  logic [DATA_W-1:0] data_r      [N_COLS];
  logic [ACC_W-1:0]  grad_r      [N_COLS];
  logic [N_COLS-1:0] valid_r;

  logic [DATA_W-1:0] inactive_s  [N_COLS];
  logic [DATA_W-1:0] active_s    [N_COLS];
  logic [DATA_W-1:0] data_s      [N_COLS];
  logic [ACC_W-1:0]  grad_s      [N_COLS];
  logic [ACC_W-1:0]  grad_base_s [N_COLS];
  logic [DATA_W-1:0] sys_data_s  [N_COLS];

  function automatic logic [DATA_W-1:0] sat_data(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum_s;
    sum_s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum_s[DATA_W] != sum_s[DATA_W-1]) begin
      sat_data = sum_s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_data = sum_s[DATA_W-1:0];
    end
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0]  acc,
                                               input logic [DATA_W-1:0] d);
    logic [ACC_W-1:0] ext_s;
    logic [ACC_W:0]   sum_s;
    ext_s = ACC_W'($signed(d));
    sum_s = {acc[ACC_W-1], acc} + {ext_s[ACC_W-1], ext_s};
    if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
      sat_acc = sum_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_acc = sum_s[ACC_W-1:0];
    end
  endfunction

  for (genvar g = 0; g < N_COLS; g++) begin : g_col
    assign sys_data_s[g]                              = bus.sys_data_in[g*DATA_W +: DATA_W];
    assign bus.data_out[g*DATA_W +: DATA_W]           = data_r[g];
    assign bus.grad_acc_out[g*ACC_W +: ACC_W]         = grad_r[g];
    assign bus.active_bias_out[g*DATA_W +: DATA_W]    = active_r[g];
  end
  assign bus.valid_out = valid_r;

  // Next-state for banks, results and gradient accumulators, column by column.
  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      inactive_s[c]  = inactive_r[c];
      active_s[c]    = active_r[c];
      data_s[c]      = data_r[c];
      grad_base_s[c] = grad_r[c];
      grad_s[c]      = grad_r[c];

      // Switch copies the pre-load inactive bank; a same-cycle load only lands in inactive.
      if (bus.load_bias_in && (bus.load_idx_in == IDX_W'(c))) begin
        inactive_s[c] = bus.bias_scalar_in;
      end else begin
        inactive_s[c] = inactive_r[c];
      end
      if (bus.bias_switch_in) begin
        active_s[c] = inactive_r[c];
      end else begin
        active_s[c] = active_r[c];
      end

      if (bus.grad_clear_in) begin
        grad_base_s[c] = {ACC_W{1'b0}};
      end else begin
        grad_base_s[c] = grad_r[c];
      end
      grad_s[c] = grad_base_s[c];

      if (bus.sys_valid_in[c]) begin
        if (bus.bias_backward_in) begin
          data_s[c] = sys_data_s[c];
          grad_s[c] = sat_acc(grad_base_s[c], sys_data_s[c]);
        end else begin
          data_s[c] = sat_data(sys_data_s[c], active_r[c]);
        end
      end else begin
        data_s[c] = data_r[c];
      end
    end
  end

  // State registers; reset clears everything immediately, discarding in-flight beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_COLS; c++) begin
        inactive_r[c] <= {DATA_W{1'b0}};
        active_r[c]   <= {DATA_W{1'b0}};
        data_r[c]     <= {DATA_W{1'b0}};
        grad_r[c]     <= {ACC_W{1'b0}};
      end
      valid_r <= {N_COLS{1'b0}};
    end else begin
      for (int c = 0; c < N_COLS; c++) begin
        inactive_r[c] <= inactive_s[c];
        active_r[c]   <= active_s[c];
        data_r[c]     <= data_s[c];
        grad_r[c]     <= grad_s[c];
      end
      valid_r <= bus.sys_valid_in;
    end
  end
endmodule

// File: tb/tb_bias_vector_unit.sv
// Directed self-checking bench for bias_vector_unit (Q8.8, 4 columns, plus a 3-column build).
module tb_bias_vector_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bias_vector_unit_if #(.N_COLS(4), .DATA_W(16), .ACC_W(24)) bus ();
  bias_vector_unit_if #(.N_COLS(3), .DATA_W(16), .ACC_W(24)) bus3 ();

  bias_vector_unit #(.N_COLS(4), .DATA_W(16), .ACC_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bias_vector_unit #(.N_COLS(3), .DATA_W(16), .ACC_W(24)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.load_bias_in     = 1'b0;
    bus.load_idx_in      = 2'd0;
    bus.bias_scalar_in   = 16'h0000;
    bus.bias_switch_in   = 1'b0;
    bus.bias_backward_in = 1'b0;
    bus.grad_clear_in    = 1'b0;
    bus.sys_valid_in     = 4'b0000;
    bus.sys_data_in      = 64'h0;
    bus3.load_bias_in     = 1'b0;
    bus3.load_idx_in      = 2'd0;
    bus3.bias_scalar_in   = 16'h0000;
    bus3.bias_switch_in   = 1'b0;
    bus3.bias_backward_in = 1'b0;
    bus3.grad_clear_in    = 1'b0;
    bus3.sys_valid_in     = 3'b000;
    bus3.sys_data_in      = 48'h0;
  endtask

  task automatic load_col(input int c, input logic [15:0] v);
    bus.load_bias_in   = 1'b1;
    bus.load_idx_in    = 2'(c);
    bus.bias_scalar_in = v;
    tick();
    bus.load_bias_in   = 1'b0;
  endtask

  task automatic do_switch;
    bus.bias_switch_in = 1'b1;
    tick();
    bus.bias_switch_in = 1'b0;
  endtask

  task automatic set_col(input int c, input logic [15:0] v);
    bus.sys_data_in[c*16 +: 16] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (bus.data_out !== 64'h0 || bus.valid_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_data: got data %h valid %b expected 0 / 0000", bus.data_out, bus.valid_out);
    end
    checks++;
    if (bus.grad_acc_out !== 96'h0 || bus.active_bias_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: got grad %h active %h expected 0", bus.grad_acc_out, bus.active_bias_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward;
    load_col(0, 16'h0100);
    load_col(1, 16'hFF00);
    do_switch();
    checks++;
    if (bus.active_bias_out !== {16'h0000, 16'h0000, 16'hFF00, 16'h0100}) begin
      errors++;
      $display("FAIL fwd_active: got %h expected 00000000ff000100", bus.active_bias_out);
    end
    bus.sys_valid_in = 4'b0011;
    set_col(0, 16'h0200);
    set_col(1, 16'h0200);
    set_col(2, 16'h1234);
    tick();
    checks++;
    if (bus.data_out !== {16'h0000, 16'h0000, 16'h0100, 16'h0300} || bus.valid_out !== 4'b0011) begin
      errors++;
      $display("FAIL fwd_add: got %h valid %b expected 0000000001000300 valid 0011", bus.data_out, bus.valid_out);
    end
    bus.sys_valid_in = 4'b0000;
    set_col(0, 16'h7777);
    tick();
    checks++;
    if (bus.data_out !== {16'h0000, 16'h0000, 16'h0100, 16'h0300} || bus.valid_out !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_hold: got %h valid %b expected 0000000001000300 valid 0000", bus.data_out, bus.valid_out);
    end
  endtask

  task automatic test_double_buffer;
    bus.load_bias_in   = 1'b1;
    bus.load_idx_in    = 2'd0;
    bus.bias_scalar_in = 16'h0500;
    bus.sys_valid_in   = 4'b0001;
    set_col(0, 16'h0200);
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0300) begin
      errors++;
      $display("FAIL dbuf_noswitch: got %h expected 0300", bus.data_out[15:0]);
    end
    bus.bias_scalar_in = 16'h0700;
    bus.bias_switch_in = 1'b1;
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0300 || bus.active_bias_out !== {16'h0000, 16'h0000, 16'hFF00, 16'h0500}) begin
      errors++;
      $display("FAIL dbuf_loadswitch: got data %h active %h expected 0300 / 00000000ff000500",
               bus.data_out[15:0], bus.active_bias_out);
    end
    bus.load_bias_in   = 1'b0;
    bus.bias_switch_in = 1'b0;
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0700) begin
      errors++;
      $display("FAIL dbuf_newbias: got %h expected 0700", bus.data_out[15:0]);
    end
    bus.sys_valid_in = 4'b0000;
    do_switch();
    checks++;
    if (bus.active_bias_out[15:0] !== 16'h0700) begin
      errors++;
      $display("FAIL dbuf_second_switch: got %h expected 0700", bus.active_bias_out[15:0]);
    end
  endtask

  task automatic test_saturation;
    load_col(0, 16'h7F00);
    load_col(1, 16'h8000);
    do_switch();
    bus.sys_valid_in = 4'b0011;
    set_col(0, 16'h0200);
    set_col(1, 16'hFF00);
    tick();
    checks++;
    if (bus.data_out[31:0] !== {16'h8000, 16'h7FFF}) begin
      errors++;
      $display("FAIL sat_clamp: got %h expected 80007fff", bus.data_out[31:0]);
    end
    set_col(0, 16'h00FF);
    set_col(1, 16'h0001);
    tick();
    checks++;
    if (bus.data_out[31:0] !== {16'h8001, 16'h7FFF}) begin
      errors++;
      $display("FAIL sat_edge: got %h expected 80017fff", bus.data_out[31:0]);
    end
    bus.sys_valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_backward;
    bus.bias_backward_in = 1'b1;
    bus.sys_valid_in = 4'b0011;
    set_col(0, 16'h0100);
    set_col(1, 16'hFF00);
    tick();
    checks++;
    if (bus.data_out[31:0] !== {16'hFF00, 16'h0100} ||
        bus.grad_acc_out !== {24'h0, 24'h0, 24'hFFFF00, 24'h000100}) begin
      errors++;
      $display("FAIL bwd_first: got data %h grad %h expected ff000100 / grad c1 ffff00 c0 000100",
               bus.data_out[31:0], bus.grad_acc_out);
    end
    bus.sys_valid_in = 4'b0001;
    set_col(0, 16'h0200);
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0200) begin
      errors++;
      $display("FAIL bwd_pass: got %h expected 0200", bus.data_out[15:0]);
    end
    set_col(0, 16'h0300);
    tick();
    checks++;
    if (bus.grad_acc_out !== {24'h0, 24'h0, 24'hFFFF00, 24'h000600}) begin
      errors++;
      $display("FAIL bwd_sum: got %h expected c1 ffff00 c0 000600", bus.grad_acc_out);
    end
    bus.grad_clear_in = 1'b1;
    set_col(0, 16'h0500);
    tick();
    bus.grad_clear_in = 1'b0;
    checks++;
    if (bus.grad_acc_out !== {24'h0, 24'h0, 24'h0, 24'h000500}) begin
      errors++;
      $display("FAIL bwd_clear: got %h expected c0 000500 others 0", bus.grad_acc_out);
    end
    set_col(0, 16'h7FFF);
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (bus.grad_acc_out[23:0] !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL bwd_acc_sat: got %h expected 7fffff", bus.grad_acc_out[23:0]);
    end
  endtask

  task automatic test_back_to_back;
    bus.bias_backward_in = 1'b1;
    bus.sys_valid_in = 4'b0001;
    set_col(0, 16'h0010);
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0010 || bus.grad_acc_out[23:0] !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL b2b_bwd: got data %h grad %h expected 0010 / 7fffff",
               bus.data_out[15:0], bus.grad_acc_out[23:0]);
    end
    bus.bias_backward_in = 1'b0;
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h7F10 || bus.grad_acc_out[23:0] !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL b2b_fwd: got data %h grad %h expected 7f10 / 7fffff",
               bus.data_out[15:0], bus.grad_acc_out[23:0]);
    end
    bus.sys_valid_in = 4'b0000;
    tick();
  endtask

  task automatic test_stagger;
    logic [3:0] pats [5];
    pats = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
    set_col(2, 16'h0030);
    set_col(3, 16'h0040);
    for (int i = 0; i < 5; i++) begin
      bus.sys_valid_in = pats[i];
      tick();
      checks++;
      if (bus.valid_out !== pats[i]) begin
        errors++;
        $display("FAIL stagger_%0d: got %b expected %b", i, bus.valid_out, pats[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.data_out[63:32] !== {16'h0040, 16'h0030}) begin
          errors++;
          $display("FAIL stagger_data: got %h expected 00400030", bus.data_out[63:32]);
        end
      end
    end
    bus.sys_valid_in = 4'b0000;
    tick();
    checks++;
    if (bus.valid_out !== 4'b0000) begin
      errors++;
      $display("FAIL stagger_drain: got %b expected 0000", bus.valid_out);
    end
  endtask

  task automatic test_idx_ignore;
    bus3.load_bias_in   = 1'b1;
    bus3.load_idx_in    = 2'd3;
    bus3.bias_scalar_in = 16'h1234;
    tick();
    bus3.load_bias_in   = 1'b0;
    bus3.bias_switch_in = 1'b1;
    tick();
    bus3.bias_switch_in = 1'b0;
    checks++;
    if (bus3.active_bias_out !== 48'h0) begin
      errors++;
      $display("FAIL idx_oob: got %h expected 0", bus3.active_bias_out);
    end
    bus3.load_bias_in   = 1'b1;
    bus3.load_idx_in    = 2'd2;
    bus3.bias_scalar_in = 16'h0022;
    tick();
    bus3.load_bias_in   = 1'b0;
    bus3.bias_switch_in = 1'b1;
    tick();
    bus3.bias_switch_in = 1'b0;
    checks++;
    if (bus3.active_bias_out !== {16'h0022, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL idx_last: got %h expected 002200000000", bus3.active_bias_out);
    end
  endtask

  task automatic test_async_reset;
    bus.sys_valid_in = 4'b0001;
    set_col(0, 16'h0200);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 64'h0 || bus.valid_out !== 4'b0000 ||
        bus.grad_acc_out !== 96'h0 || bus.active_bias_out !== 64'h0) begin
      errors++;
      $display("FAIL async_rst: got data %h valid %b grad %h active %h expected all 0",
               bus.data_out, bus.valid_out, bus.grad_acc_out, bus.active_bias_out);
    end
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.data_out !== {48'h0, 16'h0200} || bus.valid_out !== 4'b0001) begin
      errors++;
      $display("FAIL post_rst_bias0: got %h valid %b expected 0200 valid 0001", bus.data_out, bus.valid_out);
    end
    load_col(0, 16'h0100);
    do_switch();
    checks++;
    if (bus.data_out[15:0] !== 16'h0200) begin
      errors++;
      $display("FAIL post_rst_switch_cycle: got %h expected 0200", bus.data_out[15:0]);
    end
    tick();
    checks++;
    if (bus.data_out[15:0] !== 16'h0300) begin
      errors++;
      $display("FAIL post_rst_reload: got %h expected 0300", bus.data_out[15:0]);
    end
    bus.sys_valid_in = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forward();
    test_double_buffer();
    test_saturation();
    test_backward();
    test_back_to_back();
    test_stagger();
    test_idx_ignore();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
